// File: rtl/idli_fetch.sv
// Instruction fetch for idli: issues an SQI quad-read (0x03) at the current pc and
// streams returned nibbles to decode, restarting on redirect.
module idli_fetch (
    input  logic        i_fch_gck,
    input  logic        i_fch_rst_n,
    output logic        o_fch_sqi_cs_n,
    output logic [3:0]  o_fch_sqi_sio,
    output logic        o_fch_sqi_oe,
    input  logic [3:0]  i_fch_sqi_sio,
    input  logic        i_fch_redirect,
    input  logic [15:0] i_fch_redirect_pc,
    output logic [3:0]  o_fch_enc,
    output logic        o_fch_enc_vld,
    output logic        o_fch_flush,
    output logic [15:0] o_fch_pc
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_STREAM = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cyc_q, cyc_d;
    logic [1:0]  nib_q, nib_d;
    logic [15:0] pc_q, pc_d;
    logic [23:0] byte_addr;
    logic [3:0]  addr_nib;

    // Memory is byte addressed; instructions are 16-bit words.
    assign byte_addr = {7'b0, pc_q, 1'b0};

    always_comb begin
        case (cyc_q)
            3'd0:    addr_nib = byte_addr[23:20];
            3'd1:    addr_nib = byte_addr[19:16];
            3'd2:    addr_nib = byte_addr[15:12];
            3'd3:    addr_nib = byte_addr[11:8];
            3'd4:    addr_nib = byte_addr[7:4];
            default: addr_nib = byte_addr[3:0];
        endcase
    end

    always_ff @(posedge i_fch_gck or negedge i_fch_rst_n) begin
        if (!i_fch_rst_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= 3'd0;
            nib_q   <= 2'd0;
            pc_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            nib_q   <= nib_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cyc_d          = cyc_q;
        nib_d          = nib_q;
        pc_d           = pc_q;
        o_fch_sqi_cs_n = 1'b1;
        o_fch_sqi_oe   = 1'b0;
        o_fch_sqi_sio  = 4'h0;
        o_fch_enc      = 4'h0;
        o_fch_enc_vld  = 1'b0;
        // The redirect input is live during reset; keep flush quiet then.
        o_fch_flush    = i_fch_redirect & i_fch_rst_n;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_CMD;
                cyc_d   = 3'd0;
            end
            ST_CMD: begin
                o_fch_sqi_cs_n = 1'b0;
                o_fch_sqi_oe   = 1'b1;
                o_fch_sqi_sio  = cyc_q[0] ? 4'h3 : 4'h0;
                if (cyc_q == 3'd1) begin
                    state_d = ST_ADDR;
                    cyc_d   = 3'd0;
                end else begin
                    cyc_d = cyc_q + 3'd1;
                end
            end
            ST_ADDR: begin
                o_fch_sqi_cs_n = 1'b0;
                o_fch_sqi_oe   = 1'b1;
                o_fch_sqi_sio  = addr_nib;
                if (cyc_q == 3'd5) begin
                    state_d = ST_DUMMY;
                    cyc_d   = 3'd0;
                end else begin
                    cyc_d = cyc_q + 3'd1;
                end
            end
            ST_DUMMY: begin
                o_fch_sqi_cs_n = 1'b0;
                if (cyc_q == 3'd1) begin
                    state_d = ST_STREAM;
                    cyc_d   = 3'd0;
                end else begin
                    cyc_d = cyc_q + 3'd1;
                end
            end
            ST_STREAM: begin
                o_fch_sqi_cs_n = 1'b0;
                o_fch_enc      = i_fch_sqi_sio;
                o_fch_enc_vld  = 1'b1;
                nib_d          = nib_q + 2'd1;
                if (nib_q == 2'd3) begin
                    pc_d = pc_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 3'd0;
                nib_d   = 2'd0;
            end
        endcase

        // Redirect overrides everything: drop the current nibble and restart.
        if (i_fch_redirect) begin
            state_d       = ST_IDLE;
            cyc_d         = 3'd0;
            nib_d         = 2'd0;
            pc_d          = i_fch_redirect_pc;
            o_fch_enc_vld = 1'b0;
        end
    end

    assign o_fch_pc = pc_q;

endmodule

// File: tb/tb_idli_fetch.sv
// Bench for idli_fetch: reactive SQI memory model, per-cycle expectations from a
// cycle-offset reference model, queued to a negedge monitor.
module tb_idli_fetch;

    logic        gck;
    logic        rst_n;
    logic        cs_n;
    logic [3:0]  sio_o;
    logic        oe;
    logic [3:0]  sio_i;
    logic        redir;
    logic [15:0] redir_pc;
    logic [3:0]  enc;
    logic        enc_vld;
    logic        flush;
    logic [15:0] pc;

    idli_fetch dut (
        .i_fch_gck        (gck),
        .i_fch_rst_n      (rst_n),
        .o_fch_sqi_cs_n   (cs_n),
        .o_fch_sqi_sio    (sio_o),
        .o_fch_sqi_oe     (oe),
        .i_fch_sqi_sio    (sio_i),
        .i_fch_redirect   (redir),
        .i_fch_redirect_pc(redir_pc),
        .o_fch_enc        (enc),
        .o_fch_enc_vld    (enc_vld),
        .o_fch_flush      (flush),
        .o_fch_pc         (pc)
    );

    initial gck = 1'b0;
    always #5 gck = ~gck;

    typedef struct packed {
        logic        cs_n;
        logic        oe;
        logic [3:0]  sio;
        logic        vld;
        logic        flush;
        logic [15:0] pc;
        logic [3:0]  enc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: restart pc P and cycles k elapsed since the restart's IDLE cycle.
    int          k = 0;
    logic [15:0] P = 16'h0000;
    bit          in_rst = 1'b1;
    bit          pend = 1'b0;
    logic [15:0] pend_pc = 16'h0000;

    function automatic logic [15:0] memword(input logic [15:0] w);
        logic [15:0] m;
        m = w * 16'd40503;
        return m ^ 16'hA50F;
    endfunction

    function automatic logic [3:0] nib_of(input logic [15:0] w, input int i);
        logic [15:0] m;
        m = memword(w);
        return m[(15 - 4*i) -: 4];
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exq);
        checks++;
        if (act !== exq) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exq);
        end
    endtask

    task automatic build(input bit rd, output exp_t e);
        logic [23:0] a;
        int n;
        a = {7'b0, P, 1'b0};
        e.cs_n = (k == 0);
        e.oe = (k >= 1 && k <= 8);
        e.sio = 4'h0;
        if (k == 2) e.sio = 4'h3;
        if (k >= 3 && k <= 8) e.sio = a[(23 - 4*(k-3)) -: 4];
        e.vld = 1'b0;
        e.flush = rd;
        e.pc = P;
        e.enc = 4'h0;
        if (k >= 11) begin
            n = k - 11;
            e.pc = P + 16'(n / 4);
            e.vld = !rd;
            e.enc = nib_of(e.pc, n % 4);
        end
    endtask

    task automatic cyc(input bit rd, input logic [15:0] rpc, input bit rst);
        exp_t e;
        @(posedge gck);
        #1;
        if (rst) begin
            rst_n = 1'b0;
            in_rst = 1'b1;
            e = '0;
            e.cs_n = 1'b1;
        end else begin
            if (in_rst) begin
                P = 16'h0000;
                k = 0;
            end else if (pend) begin
                P = pend_pc;
                k = 0;
            end else begin
                k++;
            end
            in_rst = 1'b0;
            rst_n = 1'b1;
            build(rd, e);
        end
        redir = rd;
        redir_pc = rpc;
        pend = rd && !rst;
        pend_pc = rpc;
        exp_q.push_back(e);
    endtask

    function automatic int nextk();
        if (in_rst || pend) return 0;
        return k + 1;
    endfunction

    task automatic run_to(input int kt);
        int guard;
        guard = 0;
        while (nextk() != kt && guard < 200) begin
            cyc(1'b0, 16'h0000, 1'b0);
            guard++;
        end
    endtask

    // SQI memory: decodes the address it is sent and streams sequential words.
    initial begin
        int c;
        logic [23:0] a;
        logic [15:0] w;
        c = 0;
        a = '0;
        sio_i = 4'h0;
        forever begin
            @(posedge gck);
            #2;
            if (cs_n) begin
                c = 0;
                sio_i = 4'($urandom);
            end else begin
                if (c >= 2 && c <= 7 && oe) a = {a[19:0], sio_o};
                if (c >= 10) begin
                    w = a[16:1] + 16'((c - 10) / 4);
                    sio_i = nib_of(w, (c - 10) % 4);
                end else begin
                    sio_i = 4'($urandom);
                end
                c++;
            end
        end
    end

    // Monitor: one expected record per cycle, compared away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge gck);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cs_n",    16'(cs_n),    16'(e.cs_n));
                chk("oe",      16'(oe),      16'(e.oe));
                chk("sio",     16'(sio_o),   16'(e.sio));
                chk("enc_vld", 16'(enc_vld), 16'(e.vld));
                chk("flush",   16'(flush),   16'(e.flush));
                chk("pc",      pc,           e.pc);
                if (e.vld) chk("enc", 16'(enc), 16'(e.enc));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        redir = 1'b0;
        redir_pc = 16'h0000;

        // Reset, with a redirect inside reset that must not flush.
        cyc(1'b0, 16'h0000, 1'b1);
        cyc(1'b1, 16'hBEEF, 1'b1);
        cyc(1'b0, 16'h0000, 1'b1);
        // Cold start from pc 0 and 13 streamed nibbles.
        repeat (24) cyc(1'b0, 16'h0000, 1'b0);

        // Redirect on the 2nd nibble.
        cyc(1'b1, 16'h0100, 1'b0);
        run_to(12);
        cyc(1'b1, 16'h1234, 1'b0);
        run_to(16);

        // Redirect coincident with the 4th nibble of pc 5.
        cyc(1'b1, 16'h0005, 1'b0);
        run_to(14);
        cyc(1'b1, 16'h0040, 1'b0);
        run_to(16);

        // pc wrap.
        cyc(1'b1, 16'hFFFF, 1'b0);
        run_to(30);

        // Back-to-back redirects, the later ones landing in IDLE.
        cyc(1'b1, 16'h1111, 1'b0);
        cyc(1'b1, 16'h2222, 1'b0);
        cyc(1'b1, 16'h3333, 1'b0);
        run_to(13);

        // Reset during the address phase.
        cyc(1'b1, 16'hABCD, 1'b0);
        run_to(5);
        cyc(1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 16'h0000, 1'b1);
        run_to(14);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [15:0] rp;
            r = int'($urandom_range(0, 999));
            rp = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                              : 16'($urandom);
            if (r < 3) cyc(1'($urandom), rp, 1'b1);
            else if (r < 40) cyc(1'b1, rp, 1'b0);
            else cyc(1'b0, rp, 1'b0);
        end
        repeat (20) cyc(1'b0, 16'h0000, 1'b0);

        @(posedge gck);
        @(negedge gck);
        #1;
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idli_fetch.md
IDLI_FETCH -- requirements
Module: idli_fetch

Interface
REQ-001 i_fch_gck  input  1  clock; all state updates on the rising edge.
REQ-002 i_fch_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 o_fch_sqi_cs_n  output  1  SQI memory chip select, active-low.
REQ-004 o_fch_sqi_sio  output  4  nibble driven to memory (command/address).
REQ-005 o_fch_sqi_oe  output  1  high when o_fch_sqi_sio is driven onto the bus.
REQ-006 i_fch_sqi_sio  input  4  nibble returned by memory.
REQ-007 i_fch_redirect  input  1  restart fetch at i_fch_redirect_pc (taken branch/jump).
REQ-008 i_fch_redirect_pc  input  16  new instruction word address.
REQ-009 o_fch_enc  output  4  instruction nibble to decode, MSB nibble of each 16b instruction first.
REQ-010 o_fch_enc_vld  output  1  o_fch_enc valid this cycle.
REQ-011 o_fch_flush  output  1  one-cycle pulse telling decode to abandon any partial instruction.
REQ-012 o_fch_pc  output  16  word address of the instruction whose nibbles are being delivered.

Function
REQ-013 FSM states: IDLE, CMD, ADDR, DUMMY, STREAM; 3-bit cycle counter sequences CMD/ADDR/DUMMY.
REQ-014 IDLE: cs_n=1, oe=0, enc_vld=0; lasts exactly 1 cycle, then CMD.
REQ-015 CMD: 2 cycles, cs_n=0, oe=1, sio=4'h0 then 4'h3 (quad read 0x03).
REQ-016 ADDR: 6 cycles, cs_n=0, oe=1, sio = 24b byte address {7'b0, pc, 1'b0}, MSB nibble first.
REQ-017 DUMMY: 2 cycles, cs_n=0, oe=0 (bus turnaround), enc_vld=0.
REQ-018 STREAM: cs_n=0, oe=0, o_fch_enc = i_fch_sqi_sio (combinational), enc_vld=1; remains until redirect or reset.
REQ-019 First instruction nibble is presented 11 cycles after entering IDLE (IDLE 1 + CMD 2 + ADDR 6 + DUMMY 2).
REQ-020 2-bit nibble counter advances each STREAM cycle; on the 4th nibble (count 3) pc increments by 1 next cycle, counter wraps to 0.
REQ-021 pc wraps 16'hFFFF -> 16'h0000 with no other effect; memory stream continues sequentially.
REQ-022 o_fch_sio = 4'h0 whenever oe=0.
REQ-023 Redirect sampled in any state: that cycle enc_vld=0 and o_fch_flush=1; next cycle state=IDLE, pc=i_fch_redirect_pc, nibble counter=0, cs_n=1.
REQ-024 Redirect mid-instruction (counter 1..3): partial nibbles discarded via flush, pc not incremented.
REQ-025 Redirect in the same cycle as the 4th nibble: redirect wins, no increment, nibble not valid.
REQ-026 Back-to-back redirects: each restarts IDLE; last one's pc is used.
REQ-027 Redirect during IDLE: stays in IDLE one more cycle with new pc.
REQ-028 o_fch_flush=0 in every cycle without redirect.

Reset
REQ-029 While i_fch_rst_n=0: state=IDLE, pc=16'h0000, counters=0, cs_n=1, oe=0, sio=4'h0, enc_vld=0, flush=0.
REQ-030 Reset asserted mid-operation takes effect immediately (asynchronous); after deassertion fetch restarts from pc 0 via IDLE.

Verification
REQ-031 Reset release, memory returns 4'hA,4'h5,4'h0,4'hF... -> sio sequence 0,3,0,0,0,0,0,0 over cycles 1-8, first enc_vld at cycle 11 with enc=4'hA, pc=0.
REQ-032 Stream 8 nibbles -> pc steps 0->1 after 4th nibble, 1->2 after 8th.
REQ-033 Redirect to 16'h1234 at 2nd nibble -> flush=1, enc_vld=0 that cycle; next cycle cs_n=1; ADDR nibbles 0,0,2,4,6,8; pc=16'h1234.
REQ-034 Redirect coincident with 4th nibble of pc 5 to 16'h0040 -> no increment to 6, pc=16'h0040 next cycle.
REQ-035 pc=16'hFFFF, deliver 4 nibbles -> pc=16'h0000, stream continues, no flush.
REQ-036 Assert reset during ADDR -> outputs reach reset values immediately; after release address phase sends all-zero address.
